// File: rtl/level_sensor_filter_pkg.sv
// Shared types and limits for the level sensor filter.
//   lvl_state_t   : FSM state encoding used by the top level
//   DEBOUNCE_MIN  : smallest legal debounce length
//   FAULT_MIN     : smallest legal fault persistence length
package level_sensor_filter_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } lvl_state_t;

    localparam int DEBOUNCE_MIN = 2;
    localparam int FAULT_MIN    = 1;

endpackage

// File: rtl/level_sensor_filter_debounce_ch.sv
// One float-switch channel: 2-flop synchroniser, consecutive-difference
// counter and the debounced stable register.
//   clk_i          : clock
//   rst_i          : synchronous reset, active-high
//   raw_i          : asynchronous switch input
//   en_i           : debounce counting enabled (RUN / FAULT)
//   load_i         : take the synchronised value directly (INIT exit)
//   stable_o       : current debounced value
//   stable_nxt_o   : value the stable register takes on the next edge,
//                    so registered outputs can follow on the same edge
module level_sensor_filter_debounce_ch
    import level_sensor_filter_pkg::*;
#(
    parameter int N = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic en_i,
    input  logic load_i,
    output logic stable_o,
    output logic stable_nxt_o
);

    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    if (N < DEBOUNCE_MIN) begin : g_bad_n
        $error("debounce length below minimum");
    end

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (load_i) begin
            stable_d = s2_q;
        end else if (en_i && (s2_q != stable_q)) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o     = stable_q;
    assign stable_nxt_o = stable_d;

endmodule

// File: rtl/level_sensor_filter.sv
// Conditions the two tank float switches for the pump controller:
// synchronise + debounce each switch, reject the physically impossible
// combination (high wet while low dry), and hold a pump-off-safe 1/1
// on the outputs while not yet valid or while faulted.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active-high
//   raw_lo_i     : low float switch, async, 1 = wet
//   raw_hi_i     : high float switch, async, 1 = wet
//   fault_clr_i  : single-cycle request to leave FAULT
//   lo_wet_o     : debounced low switch (controller input a)
//   hi_wet_o     : debounced high switch (controller input b)
//   valid_o      : outputs reflect debounced sensors
//   fault_o      : implausible-combination fault latched
//
// state | meaning
// INIT  | settling after reset / fault exit, outputs forced 1/1
// RUN   | outputs follow debounced switches, watching plausibility
// FAULT | latched implausible combo, outputs forced 1/1
module level_sensor_filter
    import level_sensor_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_lo_i,
    input  logic raw_hi_i,
    input  logic fault_clr_i,
    output logic lo_wet_o,
    output logic hi_wet_o,
    output logic valid_o,
    output logic fault_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(DEBOUNCE_CYCLES + 1);
    localparam logic [FW-1:0] FCNT_TRIP = FW'(FAULT_CYCLES);

    if (FAULT_CYCLES < FAULT_MIN) begin : g_bad_f
        $error("fault length below minimum");
    end

    lvl_state_t    state_q, state_d;
    logic [CW-1:0] init_cnt_q, init_cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          deb_en, deb_load;
    logic          st_lo, st_hi, st_lo_nxt, st_hi_nxt;
    logic          implaus;
    logic          lo_q, hi_q, valid_q, fault_q;
    logic          lo_d, hi_d, valid_d, fault_d;

    level_sensor_filter_debounce_ch #(.N(DEBOUNCE_CYCLES)) u_deb_lo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .raw_i        (raw_lo_i),
        .en_i         (deb_en),
        .load_i       (deb_load),
        .stable_o     (st_lo),
        .stable_nxt_o (st_lo_nxt)
    );

    level_sensor_filter_debounce_ch #(.N(DEBOUNCE_CYCLES)) u_deb_hi (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .raw_i        (raw_hi_i),
        .en_i         (deb_en),
        .load_i       (deb_load),
        .stable_o     (st_hi),
        .stable_nxt_o (st_hi_nxt)
    );

    // Plausibility is judged on the pre-update stable values.
    assign implaus = st_hi && !st_lo;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        fcnt_d     = fcnt_q;
        deb_en     = 1'b0;
        deb_load   = 1'b0;
        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    deb_load   = 1'b1;
                    init_cnt_d = '0;
                    fcnt_d     = '0;
                    state_d    = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                deb_en = 1'b1;
                if (!implaus) begin
                    fcnt_d = '0;
                end else if (fcnt_q != FCNT_TRIP) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                if (fcnt_d == FCNT_TRIP) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                deb_en = 1'b1;
                if (fault_clr_i && !implaus) begin
                    fcnt_d     = '0;
                    init_cnt_d = '0;
                    state_d    = INIT;
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
                fcnt_d     = '0;
            end
        endcase

        // Outputs are derived from the next state so forcing lands on the
        // same edge as the state change.
        lo_d    = (state_d == RUN) ? st_lo_nxt : 1'b1;
        hi_d    = (state_d == RUN) ? st_hi_nxt : 1'b1;
        valid_d = (state_d == RUN);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            fcnt_q     <= '0;
            lo_q       <= 1'b1;
            hi_q       <= 1'b1;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            fcnt_q     <= fcnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign lo_wet_o = lo_q;
    assign hi_wet_o = hi_q;
    assign valid_o  = valid_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_level_sensor_filter.sv
module tb_level_sensor_filter;

    localparam int N = 16;
    localparam int F = 8;
    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_lo = 1'b0;
    logic raw_hi = 1'b0;
    logic fault_clr = 1'b0;
    logic lo_wet, hi_wet, valid, fault;

    always #5 clk = ~clk;

    level_sensor_filter #(.DEBOUNCE_CYCLES(N), .FAULT_CYCLES(F)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .raw_lo_i    (raw_lo),
        .raw_hi_i    (raw_hi),
        .fault_clr_i (fault_clr),
        .lo_wet_o    (lo_wet),
        .hi_wet_o    (hi_wet),
        .valid_o     (valid),
        .fault_o     (fault)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];
    bit fault_seen = 0;
    bit valid_seen = 0;

    // Reference model: switch seen two edges late, debounced value flips
    // once the last N observations all disagree with it.
    int m_mode = M_INIT;
    int m_init = 0;
    int m_fc   = 0;
    bit m_s1_lo = 0, m_s2_lo = 0, m_s1_hi = 0, m_s2_hi = 0;
    bit m_st_lo = 0, m_st_hi = 0;
    bit h_lo[$];
    bit h_hi[$];

    function automatic bit all_differ(input bit h[$], input bit st);
        if (h.size() < N) return 1'b0;
        foreach (h[i]) if (h[i] == st) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit lo, input bit hi, input bit clr);
        bit plaus;
        bit nlo, nhi;
        if (r) begin
            m_mode = M_INIT; m_init = 0; m_fc = 0;
            m_s1_lo = 0; m_s2_lo = 0; m_s1_hi = 0; m_s2_hi = 0;
            m_st_lo = 0; m_st_hi = 0;
            h_lo.delete(); h_hi.delete();
        end else begin
            plaus = !(m_st_hi && !m_st_lo);
            nlo = m_st_lo;
            nhi = m_st_hi;
            if (m_mode == M_INIT) begin
                h_lo.delete(); h_hi.delete();
                m_init++;
                if (m_init == N + 2) begin
                    nlo = m_s2_lo; nhi = m_s2_hi;
                    m_mode = M_RUN; m_init = 0; m_fc = 0;
                end
            end else begin
                h_lo.push_back(m_s2_lo);
                if (h_lo.size() > N) void'(h_lo.pop_front());
                if (all_differ(h_lo, m_st_lo)) begin nlo = !m_st_lo; h_lo.delete(); end
                h_hi.push_back(m_s2_hi);
                if (h_hi.size() > N) void'(h_hi.pop_front());
                if (all_differ(h_hi, m_st_hi)) begin nhi = !m_st_hi; h_hi.delete(); end
                if (m_mode == M_RUN) begin
                    m_fc = plaus ? 0 : m_fc + 1;
                    if (m_fc >= F) m_mode = M_FAULT;
                end else if (clr && plaus) begin
                    m_mode = M_INIT; m_init = 0; m_fc = 0;
                end
            end
            m_st_lo = nlo; m_st_hi = nhi;
            m_s2_lo = m_s1_lo; m_s2_hi = m_s1_hi;
            m_s1_lo = lo; m_s1_hi = hi;
        end
        if (m_mode == M_RUN) exp_q.push_back({m_st_lo, m_st_hi, 2'b10});
        else if (m_mode == M_FAULT) exp_q.push_back(4'b1101);
        else exp_q.push_back(4'b1100);
    endtask

    task automatic step(input bit r, input bit lo, input bit hi, input bit clr);
        @(negedge clk);
        rst = r; raw_lo = lo; raw_hi = hi; fault_clr = clr;
        model_edge(r, lo, hi, clr);
    endtask

    task automatic hold(input int n, input bit lo, input bit hi);
        for (int i = 0; i < n; i++) step(1'b0, lo, hi, 1'b0);
    endtask

    // Monitor: the DUT presents registered outputs every edge.
    initial begin
        logic [3:0] act, exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {lo_wet, hi_wet, valid, fault};
                n_checks++;
                if (act === exp) n_pass++;
                else $display("FAIL outputs t=%0t lo/hi/valid/fault got %b want %b", $time, act, exp);
                if (fault === 1'b1) fault_seen = 1;
                if (valid === 1'b1) valid_seen = 1;
            end
        end
    end

    initial begin
        int len;
        bit lo, hi;
        // Startup
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        hold(30, 1'b1, 1'b0);
        // Short low pulse, a just-long-enough pulse, then held low
        hold(15, 1'b0, 1'b0);
        hold(25, 1'b1, 1'b0);
        hold(16, 1'b0, 1'b0);
        hold(25, 1'b1, 1'b0);
        hold(40, 1'b0, 1'b0);
        // Implausible combo into fault
        hold(40, 1'b0, 1'b1);
        // Clear while implausible, then after low goes wet
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1);
        hold(25, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        hold(30, 1'b1, 1'b1);
        // Reset mid-debounce, then a fresh change
        hold(12, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        hold(25, 1'b0, 1'b0);
        hold(25, 1'b1, 1'b0);
        // High switch chatter
        for (int i = 0; i < 40; i++) hold(5, 1'b1, i[0]);
        // Randomised holds with occasional clears and resets
        for (int k = 0; k < 80; k++) begin
            lo  = 1'($urandom_range(0, 1));
            hi  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                step(1'($urandom_range(0, 300) == 0), lo, hi, 1'($urandom_range(0, 12) == 0));
        end
        hold(3, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d want 0", exp_q.size());
        n_checks++;
        if (fault_seen) n_pass++;
        else $display("FAIL fault_seen got 0 want 1");
        n_checks++;
        if (valid_seen) n_pass++;
        else $display("FAIL valid_seen got 0 want 1");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
